// File: rtl/edge_event_arbiter_if.sv
// Event output channel of edge_event_arbiter: a single valid/ready stream
// carrying the id of the reporting channel and the kind of edge it saw.
interface edge_event_arbiter_if #(
   parameter int IDW = 2
) ();

   logic           out_valid;
   logic           out_ready;
   logic [IDW-1:0] out_id;
   logic [1:0]     out_kind;

   // Producer side: the arbiter drives the event, the consumer drives ready.
   modport master (
      output out_valid,
      output out_id,
      output out_kind,
      input  out_ready
   );

   // Consumer side: an interrupt controller, log sink or testbench.
   modport slave (
      input  out_valid,
      input  out_id,
      input  out_kind,
      output out_ready
   );

endinterface

// File: rtl/edge_event_arbiter.sv
// Edge/pulse event arbiter: each of N synchronous input lines has its own
// detector (rise, fall, both, or one-cycle pulse) feeding a one-deep pending
// buffer. A round-robin scheduler drains the buffers through one registered
// valid/ready output. A sticky overflow bit records every event that arrived
// while its channel's buffer was still full.
module edge_event_arbiter #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         i_in_sig,
   input  logic [N-1:0]         i_en,
   input  logic [2*N-1:0]       i_mode,
   input  logic                 i_ovf_clr,
   edge_event_arbiter_if.master evt,
   output logic [N-1:0]         o_overflow
);

   localparam logic [1:0] KIND_RISE  = 2'd0;
   localparam logic [1:0] KIND_FALL  = 2'd1;
   localparam logic [1:0] KIND_PULSE = 2'd2;

   localparam logic [1:0] MODE_RISE  = 2'd0;
   localparam logic [1:0] MODE_FALL  = 2'd1;
   localparam logic [1:0] MODE_BOTH  = 2'd2;

   logic [N-1:0]      r_h1;
   logic [N-1:0]      r_h2;
   logic [N-1:0]      r_pend;
   logic [N-1:0][1:0] r_pkind;
   logic [N-1:0]      r_overflow;
   logic [IDW-1:0]    r_ptr;
   logic              r_outValid;
   logic [IDW-1:0]    r_outId;
   logic [1:0]        r_outKind;

   logic [N-1:0]      w_rise;
   logic [N-1:0]      w_fall;
   logic [N-1:0]      w_pulse;
   logic [N-1:0]      w_det;
   logic [N-1:0][1:0] w_detKind;
   logic              w_load;
   logic              w_grantValid;
   logic [IDW-1:0]    w_grantId;
   logic [N-1:0]      w_take;
   logic [N-1:0]      w_ovfSet;

   // Raw edge terms compare the live line with one and two cycles of history;
   // a pulse is a fall whose high phase lasted exactly one cycle.
   assign w_rise  = i_in_sig & ~r_h1;
   assign w_fall  = ~i_in_sig & r_h1;
   assign w_pulse = ~i_in_sig & r_h1 & ~r_h2;

   // The output register may take a new event when it is empty or when the
   // consumer is accepting the one it currently holds.
   assign w_load = ~r_outValid | evt.out_ready;

   // Select which edge term each channel reports according to its mode;
   // disabled channels detect nothing but keep anything already buffered.
   always_comb begin
      w_det     = '0;
      w_detKind = '0;
      for (int i = 0; i < N; i++) begin
         case (i_mode[2*i +: 2])
            MODE_RISE: begin
               w_det[i]     = w_rise[i];
               w_detKind[i] = KIND_RISE;
            end
            MODE_FALL: begin
               w_det[i]     = w_fall[i];
               w_detKind[i] = KIND_FALL;
            end
            MODE_BOTH: begin
               w_det[i]     = w_rise[i] | w_fall[i];
               w_detKind[i] = w_rise[i] ? KIND_RISE : KIND_FALL;
            end
            default: begin
               w_det[i]     = w_pulse[i];
               w_detKind[i] = KIND_PULSE;
            end
         endcase
         w_det[i] = w_det[i] & i_en[i];
      end
   end

   // Round-robin search starting one past the last granted channel; scanning
   // from the farthest candidate down lets the nearest pending one win.
   always_comb begin
      logic [IDW-1:0] cand;
      w_grantValid = 1'b0;
      w_grantId    = '0;
      cand         = '0;
      for (int k = N; k >= 1; k--) begin
         cand = IDW'((int'(r_ptr) + k) % N);
         if (r_pend[cand]) begin
            w_grantValid = 1'b1;
            w_grantId    = cand;
         end
      end
   end

   // Per-channel view of the grant: which buffer is being emptied this cycle
   // and which new events find their buffer still occupied.
   always_comb begin
      w_take   = '0;
      w_ovfSet = '0;
      for (int i = 0; i < N; i++) begin
         w_take[i]   = w_load & w_grantValid & (w_grantId == IDW'(i));
         w_ovfSet[i] = w_det[i] & r_pend[i] & ~w_take[i];
      end
   end

   // Line history shifts every cycle, independent of enable or mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_h1 <= '0;
         r_h2 <= '0;
      end else begin
         r_h1 <= i_in_sig;
         r_h2 <= r_h1;
      end
   end

   // Pending buffers: a buffer drained this cycle may refill at once; a full
   // buffer keeps its original event and flags the newcomer as dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend     <= '0;
         r_pkind    <= '0;
         r_overflow <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (w_take[i]) begin
               r_pend[i] <= w_det[i];
               if (w_det[i]) begin
                  r_pkind[i] <= w_detKind[i];
               end
            end else if (w_det[i] && !r_pend[i]) begin
               r_pend[i]  <= 1'b1;
               r_pkind[i] <= w_detKind[i];
            end
         end
         r_overflow <= (i_ovf_clr ? '0 : r_overflow) | w_ovfSet;
      end
   end

   // Output register: hold steady under backpressure, otherwise present the
   // granted event (or go idle) and move the round-robin pointer to it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outValid <= 1'b0;
         r_outId    <= '0;
         r_outKind  <= '0;
         r_ptr      <= IDW'(N - 1);
      end else if (w_load) begin
         r_outValid <= w_grantValid;
         if (w_grantValid) begin
            r_outId   <= w_grantId;
            r_outKind <= r_pkind[w_grantId];
            r_ptr     <= w_grantId;
         end
      end
   end

   assign evt.out_valid = r_outValid;
   assign evt.out_id    = r_outId;
   assign evt.out_kind  = r_outKind;
   assign o_overflow    = r_overflow;

endmodule
